// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multicycle radix-2 restoring DIV/DIVU/REM/REMU sequencer stalling IF/ID/EX; DIV_FAST_SPECIAL_EN finishes divide-by-zero/overflow in one cycle
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;
  state_t          state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] quo, rem, dvs, a_abs, b_abs, diff, q_fix, r_fix;
  logic [XLEN:0]   sh;
  logic            q_neg, r_neg, is_rem, dz, ovf, sgn_in, dz_in, ovf_in, ge, unused;
`ifdef DIV_FAST_SPECIAL_EN
  logic [XLEN-1:0] spec_res;
`endif
  assign unused = funct3[2];
  always_comb begin
    sgn_in = !funct3[0];
    a_abs  = (sgn_in && srca[XLEN-1]) ? -srca : srca;
    b_abs  = (sgn_in && srcb[XLEN-1]) ? -srcb : srcb;
    dz_in  = srcb == '0;
    ovf_in = sgn_in && srca == MIN && srcb == ONES;
`ifdef DIV_FAST_SPECIAL_EN
    spec_res = dz_in ? (funct3[1] ? srca : ONES) : (funct3[1] ? '0 : MIN);
`endif
    sh    = {rem, quo[XLEN-1]};
    ge    = sh >= {1'b0, dvs};
    diff  = sh[XLEN-1:0] - dvs;
    q_fix = dz ? ONES : ovf ? MIN : q_neg ? -quo : quo;
    r_fix = ovf ? '0 : r_neg ? -rem : rem;
    stall = (state == IDLE && start && !kill) || state == CALC || state == FIX;
    busy  = state != IDLE;
    result_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      is_rem <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else if (kill && state != IDLE) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (start && !kill) begin
          q_neg  <= sgn_in && (srca[XLEN-1] ^ srcb[XLEN-1]);
          r_neg  <= sgn_in && srca[XLEN-1];
          is_rem <= funct3[1];
          quo    <= a_abs;
          dvs    <= b_abs;
          rem    <= '0;
          count  <= '0;
          dz     <= dz_in;
          ovf    <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
          if (dz_in || ovf_in) begin
            result <= spec_res;
            state  <= DONE;
          end else begin
            state  <= CALC;
          end
`else
          state  <= CALC;
`endif
        end
        CALC: begin
          rem   <= ge ? diff : sh[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], ge};
          count <= count + 1'b1;
          if (count == CNT_W'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= is_rem ? r_fix : q_fix;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: scoreboard bench for div_seq_ctrl against an arithmetic reference model
module tb_div_seq_ctrl;
  logic        clk = 1'b0;
  logic        clr, start, kill;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  div_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .clr(clr), .start(start), .funct3(funct3), .srca(srca), .srcb(srcb),
    .kill(kill), .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
  );
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] res; int unsigned at;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0;
  logic [31:0] last_res = 32'h0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic bit special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction
  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (b == 32'h0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
    if (!f[0]) return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return f[1] ? a % b : a / b;
  endfunction
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(result_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency_cycle", cyc, e.at);
        last_res = e.res;
      end
    end
  end
  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, bit want, output int unsigned t);
    int n = 0;
    int unsigned lat;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(busy), 32'h0);
    funct3 = f; srca = a; srcb = b; start = 1'b1;
    t = cyc;
`ifdef DIV_FAST_SPECIAL_EN
    lat = special(f, a, b) ? 1 : 34;
`else
    lat = 34;
`endif
    if (want) sb.push_back('{model(f, a, b), t + lat});
    #1 chk("stall_on_start", 32'(stall), 32'h1);
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int unsigned t, t1, t2;
    logic [2:0] f;
    logic [31:0] a, b;
    clr = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b0; srca = 32'h0; srcb = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'h0);
    chk("rst_result", result, 32'h0);
    clr = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 1, t);
    repeat (32) @(negedge clk);
    chk("stall_last_cycle", 32'(stall), 32'h1);
    @(negedge clk);
    chk("stall_drop_done", 32'(stall), 32'h0);
    chk("divu_100_7", result, 32'd14);
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 1, t);
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 1, t);
    issue(3'b100, 32'd5, 32'd0, 1, t);
    issue(3'b111, 32'd5, 32'd0, 1, t);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 1, t);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 1, t);
    while (busy !== 1'b0) @(negedge clk);
    @(negedge clk);
    issue(3'b101, 32'd12345, 32'd11, 0, t);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'h0);
    chk("kill_stall", 32'(stall), 32'h0);
    chk("kill_result_held", result, last_res);
    @(negedge clk);
    issue(3'b101, 32'd1000, 32'd33, 1, t);
    while (busy !== 1'b0) @(negedge clk);
    issue(3'b100, 32'hFFFF0000, 32'd77, 0, t);
    repeat (19) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_stall", 32'(stall), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_valid", 32'(result_valid), 32'h0);
    chk("clr_result", result, 32'h0);
    clr = 1'b0;
    last_res = 32'h0;
    issue(3'b100, 32'hFFFFFC18, 32'd7, 1, t1);
    issue(3'b100, 32'd999, 32'hFFFFFFFD, 1, t2);
    chk("b2b_gap", t2 - t1, 32'd35);
    for (int i = 0; i < 40; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(f, a, b, 1, t);
    end
    for (int n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
